// File: rtl/morningjava_seg7_reader.sv
// morningjava_seg7_reader
//
// Samples an asynchronous 8-bit 7-segment bus (pgfedcba, active-high).
// It waits until the pattern has been stable for STABLE_CYCLES synchronized
// samples, then decodes it to a hex nibble plus decimal-point, blank and
// invalid flags. Each new stable pattern is reported once over valid/ready.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   segments_in   raw segment lines, bit7 = p, bit6..0 = g..a (async to clk)
//   ready         consumer accepts the current report
//   clear_overrun synchronous clear of the sticky overrun flag
//   data_out      decoded nibble (0 for blank or invalid patterns)
//   dp_out        captured decimal point (bit7)
//   blank_out     captured g..a were all zero
//   invalid_out   captured g..a is neither a hex digit nor blank
//   valid         report fields are held and valid
//   overrun       sticky; a stable pattern was lost before being reported
module morningjava_seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] segments_in,
  input  logic       ready,
  input  logic       clear_overrun,
  output logic [3:0] data_out,
  output logic       dp_out,
  output logic       blank_out,
  output logic       invalid_out,
  output logic       valid,
  output logic       overrun
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CYCLES);

  logic [7:0] sync_meta;
  logic [7:0] sync_pat;
  logic [7:0] count;
  logic [7:0] committed;
  logic [7:0] pending_pat;
  logic       pending_valid;
  logic [0:0] state;

  logic       stable;
  logic       new_event;
  logic       load_report;
  logic       release_hold;
  logic       overrun_set;
  logic [3:0] dec_data;
  logic       dec_blank;
  logic       dec_invalid;

  // Two-flop synchronizer on the whole bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 8'h00;
      sync_pat  <= 8'h00;
    end else begin
      sync_meta <= segments_in;
      sync_pat  <= sync_meta;
    end
  end

  // Run length of the synchronized value. sync_meta is the value sync_pat
  // takes on this edge, so a difference there means the run restarts at 1
  // with the new value. This lands "stable" exactly STABLE_CYCLES edges
  // after sync_pat changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (sync_meta != sync_pat) begin
      count <= 8'd1;
    end else if (count != STABLE_TARGET) begin
      count <= count + 8'd1;
    end
  end

  assign stable       = (count == STABLE_TARGET);
  assign new_event    = stable && (sync_pat != committed);
  assign release_hold = (state == ST_HOLD) && ready;
  assign load_report  = new_event && ((state == ST_IDLE) || release_hold);
  // A second, different stable pattern arrived while one was still waiting.
  // new_event already guarantees the pattern differs from committed.
  assign overrun_set  = (state == ST_HOLD) && !ready && new_event &&
                        pending_valid && (sync_pat != pending_pat);

  always_comb begin
    dec_data    = 4'h0;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (sync_pat[6:0])
      7'h3F: dec_data = 4'h0;
      7'h06: dec_data = 4'h1;
      7'h5B: dec_data = 4'h2;
      7'h4F: dec_data = 4'h3;
      7'h66: dec_data = 4'h4;
      7'h6D: dec_data = 4'h5;
      7'h7D: dec_data = 4'h6;
      7'h07: dec_data = 4'h7;
      7'h7F: dec_data = 4'h8;
      7'h67: dec_data = 4'h9;
      7'h77: dec_data = 4'hA;
      7'h7C: dec_data = 4'hB;
      7'h39: dec_data = 4'hC;
      7'h5E: dec_data = 4'hD;
      7'h79: dec_data = 4'hE;
      7'h71: dec_data = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  // Report FSM. A release with a simultaneous event reloads straight away
  // so back-to-back reports keep valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      committed   <= 8'h00;
      data_out    <= 4'h0;
      dp_out      <= 1'b0;
      blank_out   <= 1'b1;
      invalid_out <= 1'b0;
    end else if (load_report) begin
      state       <= ST_HOLD;
      committed   <= sync_pat;
      data_out    <= dec_data;
      dp_out      <= sync_pat[7];
      blank_out   <= dec_blank;
      invalid_out <= dec_invalid;
    end else if (release_hold) begin
      state <= ST_IDLE;
    end
  end

  // Remembers the pattern waiting behind a held report. It is never reported
  // from here; the release re-evaluates the live stable pattern instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_valid <= 1'b0;
      pending_pat   <= 8'h00;
    end else if (release_hold) begin
      pending_valid <= 1'b0;
    end else if ((state == ST_HOLD) && new_event) begin
      pending_valid <= 1'b1;
      pending_pat   <= sync_pat;
    end
  end

  // Sticky overrun; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign valid = (state == ST_HOLD);

endmodule

// File: tb/tb_morningjava_seg7_reader.sv
// Testbench for morningjava_seg7_reader.
// Stimulus pushes expected reports into a queue; an independent monitor pops
// and compares each report at the moment it is accepted (valid && ready).
module tb_morningjava_seg7_reader;

  localparam int S = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] segments_in;
  logic       ready;
  logic       clear_overrun;
  logic [3:0] data_out;
  logic       dp_out;
  logic       blank_out;
  logic       invalid_out;
  logic       valid;
  logic       overrun;

  int n_checks;
  int n_fail;

  // Expected report packed as {data[3:0], dp, blank, invalid}.
  logic [6:0] exp_q[$];
  logic [7:0] model_committed;
  logic [7:0] last_driven;

  logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h67, 7'h77, 7'h7C,
                                 7'h39, 7'h5E, 7'h79, 7'h71};

  morningjava_seg7_reader #(.STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .segments_in  (segments_in),
    .ready        (ready),
    .clear_overrun(clear_overrun),
    .data_out     (data_out),
    .dp_out       (dp_out),
    .blank_out    (blank_out),
    .invalid_out  (invalid_out),
    .valid        (valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: look the g..a pattern up in the digit table.
  function automatic logic [6:0] expectedReport(input logic [7:0] p);
    logic [3:0] d;
    logic       hit;
    logic       blank;
    d   = 4'h0;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_table[i] == p[6:0]) begin
        d   = i[3:0];
        hit = 1'b1;
      end
    end
    blank = (p[6:0] == 7'h00);
    return {d, p[7], blank, !hit && !blank};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Hold a pattern for a number of clocks. A hold of at least S cycles with
  // a pattern different from the last reported one yields exactly one report
  // (when modeled; ready-low scenarios push their expectations by hand).
  task automatic applyStimulus(input logic [7:0] pattern, input int cycles,
                               input bit modeled);
    segments_in = pattern;
    last_driven = pattern;
    if (modeled && cycles >= S && pattern != model_committed) begin
      exp_q.push_back(expectedReport(pattern));
      model_committed = pattern;
    end
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted report must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_report", {25'd0, data_out, dp_out, blank_out,
                    invalid_out}, 32'h7FFF_FFFF);
      end else begin
        checkOutput("report", {25'd0, data_out, dp_out, blank_out, invalid_out},
                    {25'd0, exp_q.pop_front()});
      end
    end
  end

  // Global time limit so the bench always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    model_committed = 8'h00;
    last_driven     = 8'h00;
    rst_n           = 1'b0;
    segments_in     = 8'h00;
    ready           = 1'b0;
    clear_overrun   = 1'b0;

    #12;
    checkOutput("reset_data", {28'd0, data_out}, 32'd0);
    checkOutput("reset_blank", {31'd0, blank_out}, 32'd1);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero display after reset: no event at all.
    applyStimulus(8'h00, 50, 1'b1);
    checkOutput("idle_valid", {31'd0, valid}, 32'd0);
    checkOutput("idle_blank", {31'd0, blank_out}, 32'd1);
    checkOutput("idle_overrun", {31'd0, overrun}, 32'd0);

    // Latency: valid after the 6th edge following the drive, for one cycle.
    ready       = 1'b1;
    segments_in = 8'h4F;
    last_driven = 8'h4F;
    exp_q.push_back(expectedReport(8'h4F));
    model_committed = 8'h4F;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) checkOutput("valid_before_latency", {31'd0, valid}, 32'd0);
      if (e == 6) checkOutput("valid_at_latency", {31'd0, valid}, 32'd1);
      if (e == 7) checkOutput("valid_one_cycle", {31'd0, valid}, 32'd0);
    end
    applyStimulus(8'hFC, S + 4, 1'b1);

    // Short glitch is ignored; the following blank and invalid are reported.
    applyStimulus(8'h06, S - 1, 1'b1);
    applyStimulus(8'h00, S + 4, 1'b1);
    applyStimulus(8'h12, S + 4, 1'b1);

    // Held report with two stable patterns queued behind it.
    ready = 1'b0;
    applyStimulus(8'h66, S + 4, 1'b1);
    checkOutput("held_valid", {31'd0, valid}, 32'd1);
    checkOutput("held_data", {28'd0, data_out}, 32'd4);
    applyStimulus(8'h6D, S + 4, 1'b0);
    checkOutput("pending_no_overrun", {31'd0, overrun}, 32'd0);
    applyStimulus(8'h07, S + 4, 1'b1);
    checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
    checkOutput("held_data_frozen", {28'd0, data_out}, 32'd4);
    ready = 1'b1;
    applyStimulus(8'h07, 4, 1'b1);
    checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun = 1'b0;
    checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);

    // All sixteen digits back to back at minimum spacing.
    for (int i = 0; i < 16; i++) begin
      applyStimulus({1'b0, seg_table[i]}, S, 1'b1);
    end
    applyStimulus(last_driven, 4, 1'b1);

    // Randomized runs: long holds get reported, short glitches do not.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] p;
      int         hold;
      do begin
        if ($urandom_range(0, 4) == 0) p = 8'($urandom);
        else p = {1'($urandom_range(0, 1)), seg_table[$urandom_range(0, 15)]};
      end while (p == last_driven);
      if ($urandom_range(0, 2) == 0) hold = $urandom_range(1, S - 1);
      else hold = S + $urandom_range(0, 4);
      applyStimulus(p, hold, 1'b1);
    end
    applyStimulus(last_driven, S + 4, 1'b1);

    // Asynchronous reset while a report is held.
    ready = 1'b0;
    if (last_driven == 8'h7F) applyStimulus(8'h3F, S + 4, 1'b1);
    applyStimulus(8'h7F, S + 4, 1'b0);
    checkOutput("hold_before_reset", {31'd0, valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("async_reset_blank", {31'd0, blank_out}, 32'd1);
    checkOutput("async_reset_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    model_committed = 8'h7F;
    exp_q.push_back(expectedReport(8'h7F));
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) checkOutput("post_reset_before", {31'd0, valid}, 32'd0);
      if (e == 6) checkOutput("post_reset_valid", {31'd0, valid}, 32'd1);
    end

    // Drain: every expected report must have been seen.
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
